// File: rtl/bitcell_nand_if.sv
// Bit-line bundle for one storage cell: write data, mode, row select, read data and debug tap.
interface bitcell_nand_if;
  logic in;
  logic rw;
  logic sel;
  logic out;
  logic stored_value;

  // Word/array side drives data and control and observes the cell.
  modport master (
    output in,
    output rw,
    output sel,
    input  out,
    input  stored_value
  );

  // Cell side.
  modport slave (
    input  in,
    input  rw,
    input  sel,
    output out,
    output stored_value
  );
endinterface

// File: rtl/bitcell_nand.sv
// Single-bit SRAM-style storage cell with NAND-gated combinational read path.
// Eight instances sharing rw/sel form one word.
module bitcell_nand (
  input  logic          clk,
  input  logic          rst_n,
  bitcell_nand_if.slave bus
);

  logic q;
  logic read_nand;

  // Storage bit: synchronous clear has priority over a selected write; otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (bus.sel && bus.rw) begin
      q <= bus.in;
    end
  end

  // Read gating: out = NOT(NAND(sel, NOT rw, q)); in never reaches out directly.
  always_comb begin
    read_nand = ~(bus.sel & ~bus.rw & q);
    bus.out   = ~read_nand;
  end

  assign bus.stored_value = q;

endmodule

// File: tb/tb_bitcell_nand.sv
// Bench for bitcell_nand: eight cells form a word; a word-level model is checked every cycle,
// and directed steps pin hand-computed values.
module tb_bitcell_nand;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic       rw;
  logic [7:0] w_in;
  logic [7:0] out_bus;
  logic [7:0] st_bus;

  int n_checks = 0;
  int n_fail   = 0;

  // Word-level reference: contents of the word and whether it has been reset yet.
  logic [7:0] mq;
  logic       mvalid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 8; i++) begin : g_cell
    bitcell_nand_if bus ();
    assign bus.in     = w_in[i];
    assign bus.rw     = rw;
    assign bus.sel    = sel;
    assign out_bus[i] = bus.out;
    assign st_bus[i]  = bus.stored_value;

    bitcell_nand u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: a word memory written when selected in write mode, cleared by reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      mq     <= 8'h00;
      mvalid <= 1'b1;
    end else if (sel && rw) begin
      mq <= w_in;
    end
  end

  // Per-cycle compare: a read shows the word only when selected in read mode, else zeros.
  always @(negedge clk) begin
    if (!sel || rw) begin
      chk("cycle_out_idle", out_bus, 8'h00);
    end else if (mvalid) begin
      chk("cycle_out_read", out_bus, mq);
    end
    if (mvalid) begin
      chk("cycle_stored", st_bus, mq);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    sel   = 1'b0;
    rw    = 1'b0;
    w_in  = 8'h00;
    repeat (2) tick();

    // Reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_stored", st_bus, 8'h00);
    chk("reset_out", out_bus, 8'h00);

    // Deselected write is ignored
    sel = 1'b0; rw = 1'b1; w_in = 8'hFF;
    tick();
    tick();
    @(negedge clk);
    chk("desel_write_stored", st_bus, 8'h00);
    chk("desel_write_out", out_bus, 8'h00);

    // Read returns storage, not input
    sel = 1'b1; rw = 1'b0; w_in = 8'hFF;
    @(negedge clk);
    chk("read_ignores_in_out", out_bus, 8'h00);
    chk("read_ignores_in_stored", st_bus, 8'h00);

    // Write 1s: no write-through during the write cycle
    tick();
    sel = 1'b1; rw = 1'b1; w_in = 8'hFF;
    @(negedge clk);
    chk("write_cycle_out", out_bus, 8'h00);
    chk("write_cycle_stored_before", st_bus, 8'h00);
    tick();
    rw = 1'b0; w_in = 8'h00;
    @(negedge clk);
    chk("write1_stored", st_bus, 8'hFF);
    chk("write1_read_out", out_bus, 8'hFF);

    // Deselected read
    tick();
    sel = 1'b0; rw = 1'b0;
    @(negedge clk);
    chk("desel_read_out", out_bus, 8'h00);
    chk("desel_read_stored", st_bus, 8'hFF);

    // Write 0s then read
    tick();
    sel = 1'b1; rw = 1'b1; w_in = 8'h00;
    tick();
    rw = 1'b0;
    @(negedge clk);
    chk("write0_stored", st_bus, 8'h00);
    chk("write0_read_out", out_bus, 8'h00);

    // Word patterns
    tick();
    rw = 1'b1; w_in = 8'h55;
    tick();
    rw = 1'b0; w_in = 8'h00;
    @(negedge clk);
    chk("word55_out", out_bus, 8'h55);
    tick();
    rw = 1'b1; w_in = 8'hCC;
    tick();
    rw = 1'b0; w_in = 8'h00;
    @(negedge clk);
    chk("wordCC_out", out_bus, 8'hCC);
    tick();
    sel = 1'b0;
    @(negedge clk);
    chk("wordCC_desel_out", out_bus, 8'h00);
    chk("wordCC_desel_stored", st_bus, 8'hCC);

    // Select pulse between edges does not write
    tick();
    sel = 1'b1; rw = 1'b1; w_in = 8'h33;
    #2;
    sel = 1'b0;
    tick();
    sel = 1'b1; rw = 1'b0; w_in = 8'h00;
    @(negedge clk);
    chk("glitch_stored", st_bus, 8'hCC);
    chk("glitch_out", out_bus, 8'hCC);

    // Reset during a write clears and discards the write
    tick();
    rw = 1'b1; w_in = 8'hFF;
    tick();
    @(negedge clk);
    chk("prereset_stored", st_bus, 8'hFF);
    tick();
    rst_n = 1'b0; sel = 1'b1; rw = 1'b1; w_in = 8'hFF;
    tick();
    rst_n = 1'b1; rw = 1'b0;
    @(negedge clk);
    chk("reset_write_stored", st_bus, 8'h00);
    chk("reset_write_out", out_bus, 8'h00);

    repeat (2) tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
